// File: rtl/aes_inv_cipher_ctrl.sv
// Iterative AES-128 inverse cipher: one decryption round per clock over a 128-bit
// state register, with round keys fetched combinationally from the key-schedule store.

package aes_inv_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0.
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r;
    logic [7:0] sq;
    r  = 8'h01;
    sq = x;
    for (int unsigned i = 0; i < 7; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] y;
    y = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
    return ginv(y);
  endfunction
endpackage

module aes_inv_shift_rows (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  always_comb begin
    dout = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        dout[8*(r + 4*((c + r) % 4)) +: 8] = din[8*(r + 4*c) +: 8];
      end
    end
  end
endmodule

module aes_inv_sub_bytes (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  always_comb begin
    dout = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      dout[8*i +: 8] = aes_inv_pkg::inv_sbox(din[8*i +: 8]);
    end
  end
endmodule

module aes_add_round_key (
  input  logic [0:127] din,
  input  logic [0:127] key,
  output logic [0:127] dout
);
  assign dout = din ^ key;
endmodule

module aes_inv_mix_columns (
  input  logic [0:127] din,
  output logic [0:127] dout
);
  always_comb begin
    dout = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      logic [7:0] a0, a1, a2, a3;
      a0 = din[8*(4*c)     +: 8];
      a1 = din[8*(4*c + 1) +: 8];
      a2 = din[8*(4*c + 2) +: 8];
      a3 = din[8*(4*c + 3) +: 8];
      dout[8*(4*c)     +: 8] = aes_inv_pkg::gmul(a0, 8'h0e) ^ aes_inv_pkg::gmul(a1, 8'h0b)
                             ^ aes_inv_pkg::gmul(a2, 8'h0d) ^ aes_inv_pkg::gmul(a3, 8'h09);
      dout[8*(4*c + 1) +: 8] = aes_inv_pkg::gmul(a0, 8'h09) ^ aes_inv_pkg::gmul(a1, 8'h0e)
                             ^ aes_inv_pkg::gmul(a2, 8'h0b) ^ aes_inv_pkg::gmul(a3, 8'h0d);
      dout[8*(4*c + 2) +: 8] = aes_inv_pkg::gmul(a0, 8'h0d) ^ aes_inv_pkg::gmul(a1, 8'h09)
                             ^ aes_inv_pkg::gmul(a2, 8'h0e) ^ aes_inv_pkg::gmul(a3, 8'h0b);
      dout[8*(4*c + 3) +: 8] = aes_inv_pkg::gmul(a0, 8'h0b) ^ aes_inv_pkg::gmul(a1, 8'h0d)
                             ^ aes_inv_pkg::gmul(a2, 8'h09) ^ aes_inv_pkg::gmul(a3, 8'h0e);
    end
  end
endmodule

module aes_inv_cipher_ctrl #(
  parameter int unsigned NR = 10,
  parameter int unsigned RW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [0:127]  in_data,
  output logic [RW-1:0] rk_idx,
  input  logic [0:127]  rk_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [0:127]  out_data,
  output logic          busy,
  output logic [RW-1:0] round
);
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} fsm_t;

  fsm_t         fsm;
  logic [0:127] data_q;
  logic [0:127] sr_out, sb_out, ark_in, ark_out, mc_out;

  aes_inv_shift_rows  u_isr (.din(data_q),  .dout(sr_out));
  aes_inv_sub_bytes   u_isb (.din(sr_out),  .dout(sb_out));
  aes_add_round_key   u_ark (.din(ark_in),  .key(rk_in), .dout(ark_out));
  aes_inv_mix_columns u_imc (.din(ark_out), .dout(mc_out));

  // One AddRoundKey serves the initial whitening (from in_data) and every later round.
  assign ark_in   = (fsm == IDLE) ? in_data : sb_out;
  assign out_data = data_q;

  always_comb begin
    rk_idx = '0;
    case (fsm)
      IDLE:    rk_idx = RW'(NR);
      ROUND:   rk_idx = round;
      default: rk_idx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fsm       <= IDLE;
      data_q    <= '0;
      round     <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            data_q   <= ark_out;
            round    <= RW'(NR - 1);
            fsm      <= ROUND;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ROUND: begin
          data_q <= mc_out;
          if (round == RW'(1)) begin
            round <= '0;
            fsm   <= FINAL;
          end else begin
            round <= round - RW'(1);
          end
        end
        FINAL: begin
          data_q    <= ark_out;
          fsm       <= DONE;
          busy      <= 1'b0;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            fsm       <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule
